// File: rtl/vm_dispatch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : vm_dispatch_pkg                                                     |
// | Desc   : Shared state encodings and drop-counter constants for vm_dispatcher |
// | Rev    : 1.0                                                                 |
// +----------------------------------------------------------------------------+
package vm_dispatch_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_COOL = 2'd2
  } s_state_t;

  typedef enum logic [1:0] {
    F_IDLE  = 2'd0,
    F_SERVE = 2'd1,
    F_COOL  = 2'd2
  } f_state_t;

  localparam int                      DROP_CNT_WIDTH = 16;
  localparam logic [DROP_CNT_WIDTH-1:0] DROP_CNT_MAX = {DROP_CNT_WIDTH{1'b1}};

endpackage
`default_nettype wire

// File: rtl/vm_dispatcher_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : vm_dispatcher_if                                                    |
// | Desc   : Snooper/forwarder streams and per-VM fan-out bus of vm_dispatcher   |
// | Rev    : 1.0                                                                 |
// +----------------------------------------------------------------------------+
interface vm_dispatcher_if #(
  parameter int N_VMS             = 4,
  parameter int PACKET_ADDR_WIDTH = 10,
  parameter int DATA_WIDTH        = 64
) ();
  logic [PACKET_ADDR_WIDTH-1:0]       snooper_wr_addr;
  logic [DATA_WIDTH-1:0]              snooper_wr_data;
  logic                               snooper_wr_en;
  logic                               snooper_done;
  logic                               ready_for_snooper;
  logic [PACKET_ADDR_WIDTH-1:0]       forwarder_rd_addr;
  logic                               forwarder_rd_en;
  logic [DATA_WIDTH-1:0]              forwarder_rd_data;
  logic                               forwarder_done;
  logic                               ready_for_forwarder;
  logic [PACKET_ADDR_WIDTH-1:0]       len_to_forwarder;
  logic [PACKET_ADDR_WIDTH-1:0]       vm_wr_addr;
  logic [DATA_WIDTH-1:0]              vm_wr_data;
  logic [N_VMS-1:0]                   vm_wr_en;
  logic [N_VMS-1:0]                   vm_snooper_done;
  logic [N_VMS-1:0]                   vm_ready_for_snooper;
  logic [PACKET_ADDR_WIDTH-1:0]       vm_rd_addr;
  logic [N_VMS-1:0]                   vm_rd_en;
  logic [N_VMS-1:0]                   vm_forwarder_done;
  logic [N_VMS*DATA_WIDTH-1:0]        vm_rd_data;
  logic [N_VMS-1:0]                   vm_ready_for_forwarder;
  logic [N_VMS*PACKET_ADDR_WIDTH-1:0] vm_len_to_forwarder;
  logic [15:0]                        num_packets_dropped;

  // Environment side: snooper, forwarder and the VM array
  modport master (
    output snooper_wr_addr, snooper_wr_data, snooper_wr_en, snooper_done,
    output forwarder_rd_addr, forwarder_rd_en, forwarder_done,
    output vm_ready_for_snooper, vm_rd_data, vm_ready_for_forwarder, vm_len_to_forwarder,
    input  ready_for_snooper, forwarder_rd_data, ready_for_forwarder, len_to_forwarder,
    input  vm_wr_addr, vm_wr_data, vm_wr_en, vm_snooper_done,
    input  vm_rd_addr, vm_rd_en, vm_forwarder_done, num_packets_dropped
  );

  modport slave (
    input  snooper_wr_addr, snooper_wr_data, snooper_wr_en, snooper_done,
    input  forwarder_rd_addr, forwarder_rd_en, forwarder_done,
    input  vm_ready_for_snooper, vm_rd_data, vm_ready_for_forwarder, vm_len_to_forwarder,
    output ready_for_snooper, forwarder_rd_data, ready_for_forwarder, len_to_forwarder,
    output vm_wr_addr, vm_wr_data, vm_wr_en, vm_snooper_done,
    output vm_rd_addr, vm_rd_en, vm_forwarder_done, num_packets_dropped
  );
endinterface
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : rr_arbiter                                                          |
// | Desc   : Combinational round-robin pick: first request at or above i_ptr    |
// | Rev    : 1.0                                                                 |
// +----------------------------------------------------------------------------+
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic             o_valid,
  output logic [IDX_W-1:0] o_idx
);
  logic [2*N-1:0] w_dbl;
  logic [N-1:0]   w_rot;
  logic [IDX_W:0] w_sum;

  assign w_dbl   = {i_req, i_req};
  assign w_rot   = N'(w_dbl >> i_ptr);
  assign o_valid = |i_req;

  // Scan high to low so the smallest rotated offset is the last one written
  always_comb begin
    o_idx = '0;
    w_sum = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        w_sum = (IDX_W+1)'(i) + {1'b0, i_ptr};
        if (w_sum >= (IDX_W+1)'(N)) begin
          w_sum = w_sum - (IDX_W+1)'(N);
        end
        o_idx = w_sum[IDX_W-1:0];
      end
    end
  end
endmodule
`default_nettype wire

// File: rtl/vm_dispatcher.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : vm_dispatcher                                                       |
// | Desc   : Shares one snooper/forwarder pair across N_VMS filter VMs.         |
// |          Drop counter present only with VM_DISPATCH_DROP_COUNT_EN defined.  |
// | Rev    : 1.0                                                                 |
// +----------------------------------------------------------------------------+
module vm_dispatcher
  import vm_dispatch_pkg::*;
#(
  parameter int N_VMS             = 4,
  parameter int PACKET_ADDR_WIDTH = 10,
  parameter int DATA_WIDTH        = 64
) (
  input  logic          clk,
  input  logic          rst,
  vm_dispatcher_if.slave bus
);
  localparam int IDX_W = $clog2(N_VMS);

  s_state_t         r_s_state, w_s_next;
  f_state_t         r_f_state, w_f_next;
  logic [IDX_W-1:0] r_s_ptr, r_s_sel, r_f_ptr, r_f_sel;
  logic [IDX_W-1:0] w_s_idx, w_f_idx;
  logic             w_s_valid, w_f_valid, w_fill, w_serve;
  logic [N_VMS-1:0] w_s_onehot, w_f_onehot;

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx);
    return (idx == IDX_W'(N_VMS - 1)) ? '0 : idx + 1'b1;
  endfunction

  rr_arbiter #(.N(N_VMS), .IDX_W(IDX_W)) u_s_arb (
    .i_req(bus.vm_ready_for_snooper), .i_ptr(r_s_ptr), .o_valid(w_s_valid), .o_idx(w_s_idx)
  );

  rr_arbiter #(.N(N_VMS), .IDX_W(IDX_W)) u_f_arb (
    .i_req(bus.vm_ready_for_forwarder), .i_ptr(r_f_ptr), .o_valid(w_f_valid), .o_idx(w_f_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s_state <= S_IDLE;
      r_f_state <= F_IDLE;
      r_s_ptr   <= '0;
      r_s_sel   <= '0;
      r_f_ptr   <= '0;
      r_f_sel   <= '0;
    end else begin
      r_s_state <= w_s_next;
      r_f_state <= w_f_next;
      if (r_s_state == S_IDLE && w_s_valid) begin
        r_s_sel <= w_s_idx;
        r_s_ptr <= wrap_inc(w_s_idx);
      end
      if (r_f_state == F_IDLE && w_f_valid) begin
        r_f_sel <= w_f_idx;
        r_f_ptr <= wrap_inc(w_f_idx);
      end
    end
  end

  // COOL states give the locked VM one cycle to drop its status bit
  always_comb begin
    w_s_next = r_s_state;
    w_fill   = 1'b0;
    case (r_s_state)
      S_IDLE: if (w_s_valid) w_s_next = S_FILL;
      S_FILL: begin
        w_fill = 1'b1;
        if (bus.snooper_done) w_s_next = S_COOL;
      end
      S_COOL:  w_s_next = S_IDLE;
      default: w_s_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_f_next = r_f_state;
    w_serve  = 1'b0;
    case (r_f_state)
      F_IDLE: if (w_f_valid) w_f_next = F_SERVE;
      F_SERVE: begin
        w_serve = 1'b1;
        if (bus.forwarder_done) w_f_next = F_COOL;
      end
      F_COOL:  w_f_next = F_IDLE;
      default: w_f_next = F_IDLE;
    endcase
  end

  assign w_s_onehot = N_VMS'(1) << r_s_sel;
  assign w_f_onehot = N_VMS'(1) << r_f_sel;

  assign bus.ready_for_snooper   = w_fill;
  assign bus.vm_wr_addr          = bus.snooper_wr_addr;
  assign bus.vm_wr_data          = bus.snooper_wr_data;
  assign bus.vm_wr_en            = (w_fill && bus.snooper_wr_en) ? w_s_onehot : '0;
  assign bus.vm_snooper_done     = (w_fill && bus.snooper_done)  ? w_s_onehot : '0;

  assign bus.ready_for_forwarder = w_serve;
  assign bus.vm_rd_addr          = bus.forwarder_rd_addr;
  assign bus.vm_rd_en            = (w_serve && bus.forwarder_rd_en) ? w_f_onehot : '0;
  assign bus.vm_forwarder_done   = (w_serve && bus.forwarder_done)  ? w_f_onehot : '0;
  assign bus.forwarder_rd_data   = w_serve ? bus.vm_rd_data[r_f_sel*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign bus.len_to_forwarder    = w_serve ?
      bus.vm_len_to_forwarder[r_f_sel*PACKET_ADDR_WIDTH +: PACKET_ADDR_WIDTH] : '0;

`ifdef VM_DISPATCH_DROP_COUNT_EN
  logic                      w_drop;
  logic [DROP_CNT_WIDTH-1:0] r_drop_cnt;

  assign w_drop = bus.snooper_done && !w_fill;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_drop_cnt <= '0;
    end else if (w_drop && r_drop_cnt != DROP_CNT_MAX) begin
      r_drop_cnt <= r_drop_cnt + 1'b1;
    end
  end

  assign bus.num_packets_dropped = r_drop_cnt;
`else
  assign bus.num_packets_dropped = '0;
`endif
endmodule
`default_nettype wire

// File: tb/tb_vm_dispatcher.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_vm_dispatcher                                                    |
// | Desc   : Directed self-checking bench for vm_dispatcher (N_VMS=4)           |
// | Rev    : 1.0                                                                 |
// +----------------------------------------------------------------------------+
module tb_vm_dispatcher;
  localparam int N  = 4;
  localparam int AW = 10;
  localparam int DW = 64;
`ifdef VM_DISPATCH_DROP_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  vm_dispatcher_if #(.N_VMS(N), .PACKET_ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  vm_dispatcher #(.N_VMS(N), .PACKET_ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_snoop();
    int n = 0;
    while (!bus.ready_for_snooper && n < 10) begin
      tick();
      n++;
    end
    chk("snoop_grant", 64'(bus.ready_for_snooper), 64'd1);
  endtask

  task automatic wait_fwd();
    int n = 0;
    while (!bus.ready_for_forwarder && n < 10) begin
      tick();
      n++;
    end
    chk("fwd_grant", 64'(bus.ready_for_forwarder), 64'd1);
  endtask

  // Sends nwr writes then a done pulse; returns one cycle after the done edge
  task automatic send_pkt(input int vm, input int nwr, input bit fill);
    logic [N-1:0] oh;
    oh = fill ? (N'(1) << vm) : '0;
    if (fill) wait_snoop();
    for (int k = 0; k < nwr; k++) begin
      bus.snooper_wr_en   = 1'b1;
      bus.snooper_wr_addr = AW'(k + 3);
      bus.snooper_wr_data = 64'(vm * 256 + k);
      #1;
      chk("vm_wr_en", 64'(bus.vm_wr_en), 64'(oh));
      if (k == 0) begin
        chk("vm_wr_addr", 64'(bus.vm_wr_addr), 64'd3);
        chk("vm_wr_data", bus.vm_wr_data, 64'(vm * 256));
      end
      tick();
    end
    bus.snooper_wr_en = 1'b0;
    bus.snooper_done  = 1'b1;
    #1;
    chk("vm_snooper_done", 64'(bus.vm_snooper_done), 64'(oh));
    tick();
    bus.snooper_done = 1'b0;
  endtask

  task automatic fwd_done(input logic [N-1:0] oh);
    bus.forwarder_done = 1'b1;
    #1;
    chk("vm_forwarder_done", 64'(bus.vm_forwarder_done), 64'(oh));
    tick();
    bus.forwarder_done = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    bus.snooper_wr_addr        = '0;
    bus.snooper_wr_data        = '0;
    bus.snooper_wr_en          = 1'b0;
    bus.snooper_done           = 1'b0;
    bus.forwarder_rd_addr      = '0;
    bus.forwarder_rd_en        = 1'b0;
    bus.forwarder_done         = 1'b0;
    bus.vm_ready_for_snooper   = '0;
    bus.vm_ready_for_forwarder = '0;
    bus.vm_rd_data = {64'h3333_0000_0000_0003, 64'h0000_0000_DEAD_BEEF,
                      64'h1111_0000_0000_0001, 64'h0};
    bus.vm_len_to_forwarder = {10'd20, 10'd7, 10'd10, 10'd0};
    repeat (2) tick();
    rst = 1'b0;

    // Reset state
    chk("rst_ready_snoop", 64'(bus.ready_for_snooper), 64'd0);
    chk("rst_ready_fwd", 64'(bus.ready_for_forwarder), 64'd0);
    chk("rst_vm_wr_en", 64'(bus.vm_wr_en), 64'd0);
    chk("rst_rd_data", bus.forwarder_rd_data, 64'd0);
    chk("rst_len", 64'(bus.len_to_forwarder), 64'd0);
    chk("rst_dropped", 64'(bus.num_packets_dropped), 64'd0);

    // Free-VM rotation: packets land on VMs 0, 1, 2
    bus.vm_ready_for_snooper = 4'hF;
    send_pkt(0, 4, 1'b1);
    chk("cool_ready_low", 64'(bus.ready_for_snooper), 64'd0);
    send_pkt(1, 4, 1'b1);
    send_pkt(2, 4, 1'b1);
    bus.vm_ready_for_snooper = 4'h0;
    chk("rot_dropped", 64'(bus.num_packets_dropped), 64'd0);

    // Drop counting; first stray write lands in S_COOL
    send_pkt(0, 2, 1'b0);
    send_pkt(0, 2, 1'b0);
    chk("drop_count", 64'(bus.num_packets_dropped), CNT_EN ? 64'd2 : 64'd0);

    // Drain fairness over 4'b1010
    bus.vm_ready_for_forwarder = 4'b1010;
    wait_fwd();
    chk("drain1_len", 64'(bus.len_to_forwarder), 64'd10);
    chk("drain1_data", bus.forwarder_rd_data, 64'h1111_0000_0000_0001);
    bus.forwarder_rd_en   = 1'b1;
    bus.forwarder_rd_addr = 10'd5;
    #1;
    chk("vm_rd_en", 64'(bus.vm_rd_en), 64'b0010);
    chk("vm_rd_addr", 64'(bus.vm_rd_addr), 64'd5);
    tick();
    bus.forwarder_rd_en = 1'b0;
    fwd_done(4'b0010);
    bus.vm_ready_for_forwarder = 4'b1000;
    chk("fcool_ready", 64'(bus.ready_for_forwarder), 64'd0);
    chk("fcool_data", bus.forwarder_rd_data, 64'd0);
    tick();
    chk("fidle_ready", 64'(bus.ready_for_forwarder), 64'd0);
    tick();
    chk("drain2_ready", 64'(bus.ready_for_forwarder), 64'd1);
    chk("drain2_len", 64'(bus.len_to_forwarder), 64'd20);
    chk("drain2_data", bus.forwarder_rd_data, 64'h3333_0000_0000_0003);
    fwd_done(4'b1000);

    // Read-data mux on VM2
    bus.vm_ready_for_forwarder = 4'b0100;
    wait_fwd();
    chk("mux_deadbeef", bus.forwarder_rd_data, 64'h0000_0000_DEAD_BEEF);
    chk("mux_len", 64'(bus.len_to_forwarder), 64'd7);
    fwd_done(4'b0100);
    bus.vm_ready_for_forwarder = 4'b0000;

    // Saturation: hold done high to approach the limit, then three more drops
    bus.snooper_done = 1'b1;
    repeat (CNT_EN ? 65532 : 16) tick();
    bus.snooper_done = 1'b0;
    chk("preload", 64'(bus.num_packets_dropped), CNT_EN ? 64'hFFFE : 64'd0);
    for (int i = 0; i < 3; i++) send_pkt(0, 0, 1'b0);
    chk("saturate", 64'(bus.num_packets_dropped), CNT_EN ? 64'hFFFF : 64'd0);

    // Mid-packet reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_clears_cnt", 64'(bus.num_packets_dropped), 64'd0);
    bus.vm_ready_for_snooper = 4'hF;
    wait_snoop();
    for (int k = 0; k < 2; k++) begin
      bus.snooper_wr_en = 1'b1;
      #1;
      chk("mid_vm_wr_en", 64'(bus.vm_wr_en), 64'b0001);
      tick();
    end
    bus.snooper_wr_en = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_ready_snoop", 64'(bus.ready_for_snooper), 64'd0);
    chk("mid_ready_fwd", 64'(bus.ready_for_forwarder), 64'd0);
    chk("mid_vm_wr_en0", 64'(bus.vm_wr_en), 64'd0);
    chk("mid_rd_data", bus.forwarder_rd_data, 64'd0);
    chk("mid_len", 64'(bus.len_to_forwarder), 64'd0);
    chk("mid_dropped", 64'(bus.num_packets_dropped), 64'd0);
    send_pkt(0, 2, 1'b1);

    // A done pulse during S_COOL is a drop
    bus.snooper_done = 1'b1;
    tick();
    bus.snooper_done = 1'b0;
    chk("cool_drop", 64'(bus.num_packets_dropped), CNT_EN ? 64'd1 : 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/vm_dispatcher.md
# vm_dispatcher

Sits between a single packet snooper/forwarder pair and `N_VMS` parallel `bpfvm` instances, so that several filter VMs share one ingress and one egress stream. Each incoming packet goes to a free VM, chosen round-robin. Each VM holding an accepted packet is drained to the forwarder, also round-robin. Packets arriving when no VM is free are discarded and counted.

## Interface
Parameters:
- `N_VMS`, 4: number of VM instances (2..16).
- `PACKET_ADDR_WIDTH`, 10: packet-memory word address width.
- `DATA_WIDTH`, 64: packet-memory word width.

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  reset; synchronous, active-high.
- `snooper_wr_addr`  in  PACKET_ADDR_WIDTH  write address from snooper.
- `snooper_wr_data`  in  DATA_WIDTH  write data from snooper.
- `snooper_wr_en`  in  1  write strobe from snooper.
- `snooper_done`  in  1  end-of-packet, 1-cycle pulse.
- `ready_for_snooper`  out  1  a VM is locked for filling.
- `forwarder_rd_addr`  in  PACKET_ADDR_WIDTH  read address from forwarder.
- `forwarder_rd_en`  in  1  read strobe from forwarder.
- `forwarder_rd_data`  out  DATA_WIDTH  read data from the locked VM.
- `forwarder_done`  in  1  end-of-forward, 1-cycle pulse.
- `ready_for_forwarder`  out  1  a VM is locked for draining.
- `len_to_forwarder`  out  PACKET_ADDR_WIDTH  packet length of the locked VM.
- `vm_wr_addr`, `vm_wr_data`  out  PACKET_ADDR_WIDTH / DATA_WIDTH  write address and data, broadcast to all VMs.
- `vm_wr_en`, `vm_snooper_done`  out  N_VMS  per-VM strobes.
- `vm_ready_for_snooper`  in  N_VMS  per-VM free status.
- `vm_rd_addr`  out  PACKET_ADDR_WIDTH  read address, broadcast to all VMs.
- `vm_rd_en`, `vm_forwarder_done`  out  N_VMS  per-VM strobes.
- `vm_rd_data`  in  N_VMS*DATA_WIDTH  per-VM read data; VM i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `vm_ready_for_forwarder`  in  N_VMS  per-VM packet-ready status.
- `vm_len_to_forwarder`  in  N_VMS*PACKET_ADDR_WIDTH  per-VM packet lengths, same packing as `vm_rd_data`.
- `num_packets_dropped`  out  16  drop counter.

## Operation
The ingress FSM has three states:
- S_IDLE: if any `vm_ready_for_snooper` bit is set, latch the round-robin winner into `s_sel`, advance the pointer to `s_sel+1` mod N_VMS, and go to S_FILL.
- S_FILL: `ready_for_snooper`=1. Route `snooper_wr_en` and `snooper_done` combinationally to bit `s_sel`. On `snooper_done`, go to S_COOL.
- S_COOL: one cycle with everything deasserted, so the VM's status can fall. Then go to S_IDLE.

The egress FSM has three states and is fully independent of the ingress FSM:
- F_IDLE: arbitrate over `vm_ready_for_forwarder` with a separate pointer, latch the winner into `f_sel`, and go to F_SERVE.
- F_SERVE: `ready_for_forwarder`=1. `forwarder_rd_data` and `len_to_forwarder` are muxed combinationally from `f_sel`. `forwarder_rd_en` and `forwarder_done` are routed to bit `f_sel`. On `forwarder_done`, go to F_COOL.
- F_COOL: one idle cycle, then go to F_IDLE.

Drop handling:
- Any `snooper_wr_en` outside S_FILL is discarded. It is not routed to any VM.
- `snooper_done` outside S_FILL counts as one drop. This includes a pulse in S_COOL.
- `num_packets_dropped` saturates at 16'hFFFF.

Simultaneous events:
- `snooper_wr_en` and `snooper_done` in the same S_FILL cycle are both forwarded to the VM.
- The same VM may be in S_FILL and F_SERVE at once. The VMs are ping-pong buffered, so this is legal.

Broadcast buses: `vm_wr_addr`, `vm_wr_data` and `vm_rd_addr` are wired straight through from the snooper and forwarder inputs.

## Timing
Reset (`rst`=1 at a clock edge) drives:
- Both FSMs to IDLE.
- Both round-robin pointers to 0, and `s_sel`/`f_sel` to 0.
- Counter to 0.
- `ready_for_snooper`, `ready_for_forwarder`, all `vm_*_en` and all `vm_*_done` to 0.
- `forwarder_rd_data` and `len_to_forwarder` to 0.

Reset mid-packet abandons the packet without counting a drop.

Latency:
- Grant: a request seen in IDLE at edge k gives ready=1 in cycle k+1.
- Strobes, data and length are routed with 0 cycles of latency.
- Done to next grant takes at least 2 cycles: the COOL cycle plus the IDLE cycle.

Arbitration: the search starts at the pointer and ties go to the lowest index at or above the pointer, wrapping.

## Configuration
- `VM_DISPATCH_DROP_COUNT_EN` defined: the drop counter is implemented as described above.
- `VM_DISPATCH_DROP_COUNT_EN` undefined: `num_packets_dropped` is tied to 0, no counter flops exist, and stray writes are still discarded.

## Structure
- Package `vm_dispatch_pkg` holds:
  - the ingress and egress state enums (S_IDLE/S_FILL/S_COOL, F_IDLE/F_SERVE/F_COOL);
  - the `DROP_CNT_WIDTH`=16 constant;
  - the `DROP_CNT_MAX` constant.
- One sub-module, `rr_arbiter` (request vector and pointer in, valid and index out, combinational), is instantiated twice: once for ingress, once for egress.

## Test plan
- Free-VM rotation: N_VMS=4, all VMs free, three back-to-back packets of 4 writes each, then done. Required: the packets land on VMs 0, 1, 2; `vm_wr_en` is one-hot and matches the selected VM; the counter stays 0.
- Drop counting: all `vm_ready_for_snooper`=0, send 2 packets (writes, then done). Required: no `vm_wr_en` activity; `num_packets_dropped`=2.
- Drain fairness: `vm_ready_for_forwarder`=4'b1010, with lengths 10 and 20. Required: VM1 is served first with `len_to_forwarder`=10; after done plus 2 cycles, VM3 is served with length 20.
- Read-data mux: VM2 returns 64'hDEAD_BEEF while locked in F_SERVE. Required: `forwarder_rd_data`=64'hDEAD_BEEF in the same cycle.
- Saturation: preload the counter to 16'hFFFE, then force 3 drops. Required: the counter reads 16'hFFFF. Without the macro, the counter reads 0 throughout.
- Mid-packet reset: assert `rst` after 2 writes into VM0. Required: the next cycle shows both FSMs in IDLE and all outputs 0; the next packet goes to VM0.
